reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   LC-3b general-purpose register file plus NZP condition-code register, directly upstream of the ALU.
//   Two combinational read ports (SR1, SR2) feed ALU operands a and b.
//   One synchronous write port loads the value on the shared 16-bit bus into DR.
//   The NZP flags are derived from the same bus value and feed branch evaluation.
// PARAMETERS
//   WIDTH   16  data width of each register and of the bus
//   NREGS    8  number of registers (R0..R7)
//   ADDR_W   3  register index width; must satisfy 2**ADDR_W == NREGS
// PORTS
//   clk      in   1       clock, all state updates on rising edge
//   rst      in   1       asynchronous reset, active-high
//   sr1      in   ADDR_W  read port 1 index -> sr1_out (ALU a)
//   sr2      in   ADDR_W  read port 2 index -> sr2_out (ALU b)
//   dr       in   ADDR_W  write index
//   ld_reg   in   1       write enable: R[dr] <= bus_in at clk edge
//   ld_cc    in   1       flag enable: nzp <= f(bus_in) at clk edge
//   bus_in   in   WIDTH   shared datapath bus (ALU out, memory data, PC, ...)
//   sr1_out  out  WIDTH   R[sr1], combinational
//   sr2_out  out  WIDTH   R[sr2], combinational
//   nzp      out  3       condition codes {n,z,p}, registered
// BEHAVIOUR
//   Reset (async, rst=1): R0..R7 <= 0; nzp <= 3'b010 (Z). Reads while in reset return 0.
//   Reset dominates: ld_reg/ld_cc ignored while rst=1; deassertion mid-cycle -> first write at next edge.
//   Read: sr1_out/sr2_out = R[sr1]/R[sr2], zero-cycle latency, no tri-state (never Z).
//   Same index on both read ports legal; both outputs equal.
//   Write: ld_reg=1 -> R[dr] <= bus_in at rising edge; visible on reads the cycle after.
//   ld_reg=0 -> no register changes. Single write port; no write conflicts possible.
//   R0 is an ordinary writable register (no hardwired zero).
//   CC: at edge with ld_cc=1: n=bus_in[WIDTH-1]; z=(bus_in==0); p=!n && !z.
//   Exactly one nzp bit set at all times (one-hot invariant, incl. reset).
//   ld_cc independent of ld_reg: either, both or neither may assert in a cycle; both use same bus_in.
//   ld_cc with bus_in=16'h8000 -> 100; 16'h0000 -> 010; 16'h7FFF -> 001.
//   Read-during-write on same index: see CONFIGURATION.
//   X/Z on bus_in with ld_reg/ld_cc=0 must not disturb state.
// CONFIGURATION
//   Macro REGFILE_BYPASS_EN:
//   defined: if ld_reg=1 and dr==sr1 (resp. sr2), sr1_out (resp. sr2_out) = bus_in in that same
//     cycle (write-through forwarding); storage update unchanged.
//   undefined: read-during-write returns the old R[index] until the edge; new value next cycle.
//   No other behaviour differs; nzp unaffected by the macro.
// STRUCTURE
//   Shared header lc3b.vh (alongside alu.vh): `REG_W 16, `REG_N 8, `REG_AW 3,
//     NZP bit positions `CC_N 2, `CC_Z 1, `CC_P 0, reset value `CC_RST 3'b010.
//   Sub-module nzp_gen: combinational bus_in -> {n,z,p}; reused by branch logic; reg_file registers its output.
//   Register array and read muxes stay in reg_file; no further hierarchy.
// TESTING
//   1. Assert rst mid-run after writes -> all reads 0 and nzp=010 immediately, without waiting for clk.
//   2. Write R3=16'h1234, R5=16'hFFFF; sr1=3, sr2=5 -> sr1_out=1234, sr2_out=FFFF next cycle.
//   3. ld_cc with bus_in 8000, 0000, 7FFF on successive edges -> nzp 100, 010, 001; ld_cc=0 holds.
//   4. ld_reg=1, dr=sr1=2, bus_in=ABCD, R2 old=0011 -> sr1_out=ABCD same cycle if REGFILE_BYPASS_EN, else 0011 then ABCD.
//   5. ld_reg=1, ld_cc=0, bus_in=0000 -> reg written, nzp unchanged; ld_reg=0, ld_cc=1 -> no reg change.
//   6. Random writes/reads all 8 indices vs scoreboard model, both macro settings; nzp one-hot assertion always.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared LC-3b register-file constants: data/index widths, NZP bit positions and the flag reset value.
package reg_file_pkg;
    localparam int REG_W  = 16;
    localparam int REG_N  = 8;
    localparam int REG_AW = 3;

    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    localparam logic [2:0] CC_RST = 3'b010;

    typedef logic [2:0] nzp_t;
endpackage

// File: rtl/reg_file_nzp_gen.sv
// Combinational condition-code generator: classifies a bus value as negative, zero or positive.
module nzp_gen
    import reg_file_pkg::*;
#(
    parameter int WIDTH = REG_W
) (
    input  logic [WIDTH-1:0] bus_in,
    output nzp_t             nzp
);
    always_comb begin
        nzp       = '0;
        nzp[CC_N] = bus_in[WIDTH-1];
        nzp[CC_Z] = (bus_in == '0);
        nzp[CC_P] = !bus_in[WIDTH-1] && (bus_in != '0);
    end
endmodule

// File: rtl/reg_file.sv
// LC-3b register file (R0..R7, two combinational read ports, one write port) plus the NZP register.
// Define REGFILE_BYPASS_EN to forward bus_in to a read port whose index is being written this cycle.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int NREGS  = REG_N,
    parameter int ADDR_W = REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    input  logic [ADDR_W-1:0] dr,
    input  logic              ld_reg,
    input  logic              ld_cc,
    input  logic [WIDTH-1:0]  bus_in,
    output logic [WIDTH-1:0]  sr1_out,
    output logic [WIDTH-1:0]  sr2_out,
    output nzp_t              nzp
);
    logic [WIDTH-1:0] regs [NREGS];
    nzp_t             nzp_next;

    nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
        .bus_in (bus_in),
        .nzp    (nzp_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (ld_reg) begin
            regs[dr] <= bus_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzp <= CC_RST;
        end else if (ld_cc) begin
            nzp <= nzp_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed in reset so reads still return the cleared contents.
    always_comb begin
        sr1_out = regs[sr1];
        sr2_out = regs[sr2];
        if (ld_reg && !rst && (dr == sr1)) begin
            sr1_out = bus_in;
        end
        if (ld_reg && !rst && (dr == sr2)) begin
            sr2_out = bus_in;
        end
    end
`else
    always_comb begin
        sr1_out = regs[sr1];
        sr2_out = regs[sr2];
    end
`endif
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic        ld_reg;
    logic        ld_cc;
    logic [15:0] bus_in;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic [2:0]  nzp;

    int          n_cmp;
    int          n_err;
    logic [15:0] model [8];
    logic [15:0] exp_q [$];
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    bit          done;

    reg_file dut (
        .clk     (clk),
        .rst     (rst),
        .sr1     (sr1),
        .sr2     (sr2),
        .dr      (dr),
        .ld_reg  (ld_reg),
        .ld_cc   (ld_cc),
        .bus_in  (bus_in),
        .sr1_out (sr1_out),
        .sr2_out (sr2_out),
        .nzp     (nzp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive_cycle(input logic lr, input logic lc, input logic [2:0] d, input logic [15:0] v);
        @(negedge clk);
        ld_reg = lr;
        ld_cc  = lc;
        dr     = d;
        bus_in = v;
        @(posedge clk);
        #1;
        ld_reg = 1'b0;
        ld_cc  = 1'b0;
        if (lr) model[d] = v;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [2:0] b);
        sr1 = a;
        sr2 = b;
        #1;
        check_eq({tag, "_sr1"}, sr1_out, model[a]);
        check_eq({tag, "_sr2"}, sr2_out, model[b]);
    endtask

    // one-hot flag invariant, sampled away from the active edge
    always @(negedge clk) begin
        if (!done) check_eq("nzp_onehot", {15'd0, $onehot(nzp)}, 16'd1);
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        done   = 1'b0;
        rst    = 1'b1;
        sr1    = 3'd0;
        sr2    = 3'd0;
        dr     = 3'd0;
        ld_reg = 1'b0;
        ld_cc  = 1'b0;
        bus_in = 16'h0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0;

        // reset state, with enables asserted to show reset dominance
        #2;
        ld_reg = 1'b1;
        ld_cc  = 1'b1;
        bus_in = 16'h8000;
        @(posedge clk);
        #1;
        check_eq("rst_nzp", {13'd0, nzp}, 16'h0002);
        read_check("rst_r0", 3'd0, 3'd7);
        ld_reg = 1'b0;
        ld_cc  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // basic writes
        drive_cycle(1'b1, 1'b0, 3'd3, 16'h1234);
        drive_cycle(1'b1, 1'b0, 3'd5, 16'hFFFF);
        sr1 = 3'd3;
        sr2 = 3'd5;
        #1;
        check_eq("wr_r3", sr1_out, 16'h1234);
        check_eq("wr_r5", sr2_out, 16'hFFFF);
        read_check("same_idx", 3'd5, 3'd5);

        // condition codes
        drive_cycle(1'b0, 1'b1, 3'd0, 16'h8000);
        check_eq("cc_neg", {13'd0, nzp}, 16'h0004);
        drive_cycle(1'b0, 1'b1, 3'd0, 16'h0000);
        check_eq("cc_zero", {13'd0, nzp}, 16'h0002);
        drive_cycle(1'b0, 1'b1, 3'd0, 16'h7FFF);
        check_eq("cc_pos", {13'd0, nzp}, 16'h0001);
        drive_cycle(1'b0, 1'b0, 3'd0, 16'h8000);
        check_eq("cc_hold", {13'd0, nzp}, 16'h0001);

        // ld_reg and ld_cc independent
        drive_cycle(1'b1, 1'b0, 3'd6, 16'h0000);
        check_eq("ldreg_only_nzp", {13'd0, nzp}, 16'h0001);
        read_check("ldreg_only_r6", 3'd6, 3'd3);
        drive_cycle(1'b0, 1'b1, 3'd6, 16'h8000);
        check_eq("ldcc_only_nzp", {13'd0, nzp}, 16'h0004);
        read_check("ldcc_only_r6", 3'd6, 3'd5);
        drive_cycle(1'b1, 1'b1, 3'd1, 16'h0042);
        check_eq("both_nzp", {13'd0, nzp}, 16'h0001);
        read_check("both_r1", 3'd1, 3'd0);

        // read during write
        drive_cycle(1'b1, 1'b0, 3'd2, 16'h0011);
        @(negedge clk);
        sr1    = 3'd2;
        sr2    = 3'd3;
        dr     = 3'd2;
        bus_in = 16'hABCD;
        ld_reg = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("rdw_same", sr1_out, 16'hABCD);
`else
        check_eq("rdw_same", sr1_out, 16'h0011);
`endif
        check_eq("rdw_other", sr2_out, 16'h1234);
        @(posedge clk);
        #1;
        ld_reg   = 1'b0;
        model[2] = 16'hABCD;
        check_eq("rdw_next", sr1_out, 16'hABCD);

        // X on bus with enables low must not disturb state
        drive_cycle(1'b0, 1'b0, 3'd2, 16'hxxxx);
        check_eq("x_nzp", {13'd0, nzp}, 16'h0001);
        read_check("x_r2", 3'd2, 3'd1);

        // all indices through the scoreboard
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b0, 3'(i), 16'hA5A0 + 16'(i) * 16'h0101);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'hA5A0 + 16'(i) * 16'h0101);
            exp_q.push_back(16'hA5A0 + 16'(7 - i) * 16'h0101);
        end
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            sr2 = 3'(7 - i);
            #1;
            exp_a = exp_q.pop_front();
            exp_b = exp_q.pop_front();
            check_eq("sb_sr1", sr1_out, exp_a);
            check_eq("sb_sr2", sr2_out, exp_b);
        end

        // asynchronous reset mid-run
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_nzp", {13'd0, nzp}, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            model[i] = 16'h0;
        end
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            sr2 = 3'(7 - i);
            #1;
            check_eq("arst_sr1", sr1_out, 16'h0000);
            check_eq("arst_sr2", sr2_out, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 1'b1, 3'd4, 16'hBEEF);
        check_eq("post_rst_nzp", {13'd0, nzp}, 16'h0004);
        read_check("post_rst_r4", 3'd4, 3'd0);

        @(negedge clk);
        done = 1'b1;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
